// File: rtl/play_sequencer.sv
// rtl/play_sequencer.sv - song ROM walker driving the tone generator
// Fetches {len, pitch} words, plays each for len * speed-scaled ticks, supports pause/resume.
module play_sequencer #(
  parameter int TICK_CYCLES = 1_000_000,
  parameter int IDX_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       song_select,
  input  logic [1:0]       speed_select,
  output logic [IDX_W+1:0] rom_addr,
  input  logic [7:0]       rom_data,
  output logic [4:0]       note_out,
  output logic             note_valid,
  output logic             playing,
  output logic             paused,
  output logic             song_done
);

  localparam int CW = $clog2(2 * TICK_CYCLES);

  // Periods are stored minus one so the slowest speed still fits in CW bits.
  localparam logic [CW-1:0] LAST_NORMAL  = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] LAST_FAST    = CW'(TICK_CYCLES / 2 - 1);
  localparam logic [CW-1:0] LAST_SLOW    = CW'(TICK_CYCLES * 2 - 1);
  localparam logic [CW-1:0] LAST_FASTEST = CW'(TICK_CYCLES / 4 - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic             start_d;
  logic             press;
  logic [1:0]       song_latched;
  logic [1:0]       song_nx;
  logic [IDX_W-1:0] note_idx;
  logic [IDX_W-1:0] idx_nx;
  logic [4:0]       pitch_nx;
  logic [2:0]       len_latched;
  logic [CW-1:0]    period_last;
  logic [CW-1:0]    period_sel;
  logic [CW-1:0]    cyc_cnt;
  logic [2:0]       unit_cnt;
  logic             unit_wrap;
  logic             note_complete;
  logic             last_note;
  logic             finish;

  assign press         = start & ~start_d;
  assign unit_wrap     = (cyc_cnt == period_last);
  assign note_complete = unit_wrap && (unit_cnt == len_latched - 3'd1);
  assign last_note     = &note_idx;

  always_comb begin
    case (speed_select)
      2'b00:   period_sel = LAST_NORMAL;
      2'b01:   period_sel = LAST_FAST;
      2'b10:   period_sel = LAST_SLOW;
      default: period_sel = LAST_FASTEST;
    endcase
  end

  always_comb begin
    state_nx = state;
    song_nx  = song_latched;
    idx_nx   = note_idx;
    pitch_nx = note_out;
    finish   = 1'b0;
    case (state)
      S_IDLE: begin
        if (press) begin
          state_nx = S_FETCH;
          song_nx  = song_select;
          idx_nx   = '0;
        end
      end
      S_FETCH: state_nx = S_LOAD;
      S_LOAD: begin
        if (rom_data[7:5] == 3'd0) begin
          state_nx = S_IDLE;
          finish   = 1'b1;
        end else begin
          state_nx = S_PLAY;
          pitch_nx = rom_data[4:0];
        end
      end
      S_PLAY: begin
        // A press on the completing cycle wins; the held counters finish the note on resume.
        if (press) begin
          state_nx = S_PAUSE;
        end else if (note_complete) begin
          if (last_note) begin
            state_nx = S_IDLE;
            finish   = 1'b1;
          end else begin
            state_nx = S_FETCH;
            idx_nx   = note_idx + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (press) state_nx = S_PLAY;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      start_d      <= 1'b1;
      song_latched <= 2'd0;
      note_idx     <= '0;
      note_out     <= 5'd0;
      len_latched  <= 3'd0;
      period_last  <= '0;
      cyc_cnt      <= '0;
      unit_cnt     <= 3'd0;
      rom_addr     <= '0;
      note_valid   <= 1'b0;
      playing      <= 1'b0;
      paused       <= 1'b0;
      song_done    <= 1'b0;
    end else begin
      state        <= state_nx;
      start_d      <= start;
      song_latched <= song_nx;
      note_idx     <= idx_nx;
      note_out     <= pitch_nx;
      rom_addr     <= {song_nx, idx_nx};
      note_valid   <= (state_nx == S_PLAY) && (pitch_nx != 5'd0);
      playing      <= state_nx inside {S_FETCH, S_LOAD, S_PLAY};
      paused       <= (state_nx == S_PAUSE);
      song_done    <= finish;
      if (state == S_LOAD) begin
        len_latched <= rom_data[7:5];
        period_last <= period_sel;
        cyc_cnt     <= '0;
        unit_cnt    <= 3'd0;
      end else if (state == S_PLAY && !note_complete) begin
        if (unit_wrap) begin
          cyc_cnt  <= '0;
          unit_cnt <= unit_cnt + 3'd1;
        end else begin
          cyc_cnt <= cyc_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_play_sequencer.sv
// tb/tb_play_sequencer.sv - bench for play_sequencer
// Song timelines are predicted from the note list and compared cycle by cycle.
module tb_play_sequencer;

  localparam int TICK = 4;
  localparam int IW   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] song_select;
  logic [1:0] speed_select;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [4:0] note_out;
  logic       note_valid;
  logic       playing;
  logic       paused;
  logic       song_done;

  logic [7:0] rom [16];
  int         vectors = 0;
  int         miscompares = 0;
  logic [4:0] exp_note;

  typedef struct packed {
    logic [3:0] addr;
    logic [4:0] note;
    logic       nv;
    logic       play;
    logic       pause;
    logic       done;
  } obs_t;

  typedef struct {
    logic [1:0] speed;
    logic [2:0] len;
    int         exp_valid;
    int         exp_done;
  } spd_vec_t;

  obs_t expq[$];

  play_sequencer #(.TICK_CYCLES(TICK), .IDX_W(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .song_select (song_select),
    .speed_select(speed_select),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .note_out    (note_out),
    .note_valid  (note_valid),
    .playing     (playing),
    .paused      (paused),
    .song_done   (song_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic obs_t observe();
    return {rom_addr, note_out, note_valid, playing, paused, song_done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    step();
    exp_note = 5'd0;
  endtask

  function automatic int period_of(input logic [1:0] sp);
    case (sp)
      2'd0:    return TICK;
      2'd1:    return TICK / 2;
      2'd2:    return TICK * 2;
      default: return TICK / 4;
    endcase
  endfunction

  // Expected outputs from the cycle after the press until one idle cycle past song_done.
  task automatic build(input logic [1:0] s, input int period);
    logic [4:0] cur;
    logic [3:0] a;
    logic [2:0] len;
    logic [4:0] pitch;
    logic       ended;
    cur   = exp_note;
    ended = 1'b0;
    for (int i = 0; i < 4 && !ended; i++) begin
      a     = {s, 2'(i)};
      len   = rom[a][7:5];
      pitch = rom[a][4:0];
      expq.push_back({a, cur, 1'b0, 1'b1, 1'b0, 1'b0});
      expq.push_back({a, cur, 1'b0, 1'b1, 1'b0, 1'b0});
      if (len == 3'd0) begin
        expq.push_back({a, cur, 1'b0, 1'b0, 1'b0, 1'b1});
        expq.push_back({a, cur, 1'b0, 1'b0, 1'b0, 1'b0});
        ended = 1'b1;
      end else begin
        cur = pitch;
        repeat (int'(len) * period) expq.push_back({a, cur, pitch != 5'd0, 1'b1, 1'b0, 1'b0});
        if (i == 3) begin
          expq.push_back({a, cur, 1'b0, 1'b0, 1'b0, 1'b1});
          expq.push_back({a, cur, 1'b0, 1'b0, 1'b0, 1'b0});
        end
      end
    end
    exp_note = cur;
  endtask

  task automatic run_song(input logic [1:0] s, input logic [1:0] sp, input string tag);
    obs_t want;
    build(s, period_of(sp));
    song_select  = s;
    speed_select = sp;
    start = 1'b1;
    step();
    start = 1'b0;
    while (expq.size() > 0) begin
      want = expq.pop_front();
      check(tag, 32'(observe()), 32'(want));
      song_select = 2'($urandom);
      step();
    end
  endtask

  initial begin
    spd_vec_t tbl[7];
    int       nv_cnt;
    int       done_at;
    logic     seen;
    int       len;

    tbl[0] = '{2'd0, 3'd1, 4, 9};
    tbl[1] = '{2'd1, 3'd1, 2, 7};
    tbl[2] = '{2'd2, 3'd1, 8, 13};
    tbl[3] = '{2'd3, 3'd1, 1, 6};
    tbl[4] = '{2'd1, 3'd3, 6, 11};
    tbl[5] = '{2'd2, 3'd7, 56, 61};
    tbl[6] = '{2'd3, 3'd5, 5, 10};

    for (int i = 0; i < 16; i++) rom[i] = 8'd0;
    reset = 1'b1;
    start = 1'b1;
    song_select  = 2'd0;
    speed_select = 2'd0;
    exp_note = 5'd0;
    step();
    step();
    check("reset_state", 32'(observe()), 32'd0);

    // Start held through reset release must not register as a press.
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("held_start_idle", 32'({rom_addr, playing}), 32'd0);
    end
    start = 1'b0;
    step();
    step();

    rom[4] = {3'd1, 5'd5};
    rom[5] = {3'd2, 5'd0};
    rom[6] = 8'd0;
    run_song(2'd1, 2'd0, "song1_rest");

    rom[8]  = {3'd1, 5'd3};
    rom[9]  = {3'd1, 5'd4};
    rom[10] = {3'd2, 5'd0};
    rom[11] = {3'd1, 5'd6};
    run_song(2'd2, 2'd3, "four_notes");

    for (int r = 0; r < 7; r++) begin
      rom[12] = {tbl[r].len, 5'd17};
      rom[13] = 8'd0;
      song_select  = 2'd3;
      speed_select = tbl[r].speed;
      start = 1'b1;
      step();
      start = 1'b0;
      nv_cnt  = 0;
      done_at = -1;
      for (int j = 1; j <= 80; j++) begin
        if (note_valid) nv_cnt++;
        if (song_done && done_at < 0) done_at = j;
        step();
      end
      check("speed_valid_cycles", 32'(nv_cnt), 32'(tbl[r].exp_valid));
      check("speed_done_latency", 32'(done_at), 32'(tbl[r].exp_done));
    end

    // Pause on the 2nd PLAY cycle of an 8-cycle note, hold 10 cycles, resume.
    rom[12] = {3'd2, 5'd9};
    rom[13] = 8'd0;
    speed_select = 2'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("pause_nv_first", 32'(note_valid), 32'd1);
    step();
    check("pause_nv_second", 32'(note_valid), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("pause_hold", 32'({paused, note_valid}), 32'd2);
      if (k == 9) start = 1'b1;
      step();
    end
    start = 1'b0;
    nv_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      if (note_valid) nv_cnt++;
      step();
    end
    check("pause_resume_nv", 32'(nv_cnt), 32'd6);

    // Press lands on the completing cycle of a 1-cycle note.
    rom[12] = {3'd1, 5'd7};
    speed_select = 2'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("simul_play", 32'(note_valid), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("simul_paused", 32'({paused, note_valid}), 32'd2);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("simul_resume", 32'({paused, note_valid}), 32'd1);
    step();
    check("simul_next_fetch", 32'({rom_addr, playing, note_valid}), 32'({4'd13, 1'b1, 1'b0}));
    step();
    step();
    check("simul_done", 32'({song_done, playing}), 32'd2);

    // Reset in the middle of a note discards progress.
    rom[12] = {3'd3, 5'd11};
    speed_select = 2'd0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("reset_mid_play_nv", 32'(note_valid), 32'd1);
    reset = 1'b1;
    step();
    check("reset_mid_outputs", 32'(observe()), 32'd0);
    reset = 1'b0;
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_addr", 32'({rom_addr, playing}), 32'({4'd12, 1'b1}));
    seen = 1'b0;
    for (int j = 0; j < 100 && !seen; j++) begin
      if (song_done) seen = 1'b1;
      step();
    end
    check("restart_done", 32'(seen), 32'd1);

    do_reset();
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 16; i++) begin
        len = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 7));
        rom[i] = {3'(len), 5'($urandom_range(0, 31))};
      end
      step();
      run_song(2'($urandom), 2'($urandom), "random_song");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
